// File: rtl/my_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : my_arbiter_pkg
// Purpose  : Shared constants and state encoding for the 8-way round-robin
//            arbiter (my_arbiter_16_8_way) and its rotating-priority picker.
// Contents : N_REQ  - number of requesters
//            SEL_W  - width of a binary requester index
//            DATA_W - width of a requester data word
//            state_t - arbiter FSM state (IDLE / BUSY)
// Revision : 1.0 - initial release
// ============================================================================
package my_arbiter_pkg;

  localparam int N_REQ  = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage : my_arbiter_pkg
`default_nettype wire

// File: rtl/my_mux_16_8_way.sv
`default_nettype none
// ============================================================================
// Module   : my_mux_16_8_way
// Purpose  : 8-to-1 multiplexer of 16-bit words (existing datapath block).
// Ports    : sel [2:0]        - binary select, 0 selects a ... 7 selects h
//            a..h [15:0]      - candidate data words
//            out [15:0]       - selected word (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module my_mux_16_8_way (
  input  logic [2:0]  sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  output logic [15:0] out
);

  always_comb begin
    out = a;
    case (sel)
      3'd0:    out = a;
      3'd1:    out = b;
      3'd2:    out = c;
      3'd3:    out = d;
      3'd4:    out = e;
      3'd5:    out = f;
      3'd6:    out = g;
      3'd7:    out = h;
      default: out = a;
    endcase
  end

endmodule : my_mux_16_8_way
`default_nettype wire

// File: rtl/my_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : my_rr_pick
// Purpose  : Combinational rotating-priority picker. Searches the request
//            vector starting at index ptr and wrapping 7 -> 0, returning the
//            first index whose request bit is set.
// Ports    : req  [7:0] - request lines, bit0 = requester a
//            ptr  [2:0] - highest-priority index for this search
//            pick [2:0] - first requesting index in search order (0 if none)
//            any        - at least one request is active
// Revision : 1.0 - initial release
// ============================================================================
module my_rr_pick
  import my_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  // Walk the eight positions in priority order; the 3-bit add wraps the
  // index naturally so no explicit modulo is needed.
  always_comb begin
    pick    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = ptr + i[SEL_W-1:0];
      if (!w_found && req[w_idx]) begin
        pick    = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule : my_rr_pick
`default_nettype wire

// File: rtl/my_arbiter_16_8_way.sv
`default_nettype none
// ============================================================================
// Module   : my_arbiter_16_8_way
// Purpose  : Round-robin arbiter sharing one registered 16-bit output channel
//            among eight requesters a..h. The winner's word is captured
//            through my_mux_16_8_way and held valid until the consumer
//            accepts it. Accept and re-arbitration happen on the same edge,
//            giving one word per cycle under continuous demand.
// Params   : PTR_INIT   - requester index with highest priority after reset
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-high reset
//            req  [7:0] - request lines, bit0 = a ... bit7 = h
//            a..h [15:0]- requester data words
//            ready      - consumer accepts out this cycle when valid = 1
//            out  [15:0]- registered granted word
//            valid      - out holds an unaccepted word
//            grant[7:0] - one-hot current owner, 0 when valid = 0
//            sel  [2:0] - binary index of current owner
//            xfer_count - accepted transfers, wraps at 2^16
// Revision : 1.0 - initial release
// ============================================================================
module my_arbiter_16_8_way
  import my_arbiter_pkg::*;
#(
  parameter int unsigned PTR_INIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] h,
  input  logic              ready,
  output logic [DATA_W-1:0] out,
  output logic              valid,
  output logic [N_REQ-1:0]  grant,
  output logic [SEL_W-1:0]  sel,
  output logic [15:0]       xfer_count
);

  localparam logic [SEL_W-1:0] c_ptr_init = PTR_INIT[SEL_W-1:0];

  // Registered state
  state_t            r_state;
  logic [SEL_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_out;
  logic              r_valid;
  logic [N_REQ-1:0]  r_grant;
  logic [SEL_W-1:0]  r_sel;
  logic [15:0]       r_xfer_count;

  // Next-state values
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  w_ptr_nxt;
  logic [DATA_W-1:0] w_out_nxt;
  logic              w_valid_nxt;
  logic [N_REQ-1:0]  w_grant_nxt;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [15:0]       w_xfer_count_nxt;

  // Arbitration datapath
  logic              w_accept;
  logic [SEL_W-1:0]  w_search_ptr;
  logic [SEL_W-1:0]  w_pick;
  logic              w_any;
  logic [DATA_W-1:0] w_mux_out;

  assign w_accept = r_valid & ready;

  // On an accept the rotation takes effect in the same edge, so the search
  // must already start just past the departing owner rather than at r_ptr.
  assign w_search_ptr = w_accept ? (r_sel + SEL_W'(1)) : r_ptr;

  my_rr_pick u_pick (
    .req  (req),
    .ptr  (w_search_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  my_mux_16_8_way u_mux (
    .sel (w_pick),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .f   (f),
    .g   (g),
    .h   (h),
    .out (w_mux_out)
  );

  // Next-state / output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_out_nxt        = r_out;
    w_valid_nxt      = r_valid;
    w_grant_nxt      = r_grant;
    w_sel_nxt        = r_sel;
    w_xfer_count_nxt = r_xfer_count;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_sel_nxt   = w_pick;
          w_grant_nxt = N_REQ'(1) << w_pick;
          w_out_nxt   = w_mux_out;
          w_valid_nxt = 1'b1;
          w_state_nxt = BUSY;
        end
      end

      BUSY: begin
        // Without an accept everything is frozen, even if the owner has
        // withdrawn its request: the captured word must still be delivered.
        if (w_accept) begin
          w_ptr_nxt        = w_search_ptr;
          w_xfer_count_nxt = r_xfer_count + 16'd1;
          if (w_any) begin
            w_sel_nxt   = w_pick;
            w_grant_nxt = N_REQ'(1) << w_pick;
            w_out_nxt   = w_mux_out;
            w_valid_nxt = 1'b1;
          end else begin
            // sel and out keep the last delivered word
            w_valid_nxt = 1'b0;
            w_grant_nxt = '0;
            w_state_nxt = IDLE;
          end
        end
      end

      default: begin
        w_valid_nxt = 1'b0;
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ptr        <= c_ptr_init;
      r_out        <= '0;
      r_valid      <= 1'b0;
      r_grant      <= '0;
      r_sel        <= '0;
      r_xfer_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_out        <= w_out_nxt;
      r_valid      <= w_valid_nxt;
      r_grant      <= w_grant_nxt;
      r_sel        <= w_sel_nxt;
      r_xfer_count <= w_xfer_count_nxt;
    end
  end

  assign out        = r_out;
  assign valid      = r_valid;
  assign grant      = r_grant;
  assign sel        = r_sel;
  assign xfer_count = r_xfer_count;

endmodule : my_arbiter_16_8_way
`default_nettype wire

// File: tb/tb_my_arbiter_16_8_way.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_arbiter_16_8_way
// Purpose  : Self-checking bench for my_arbiter_16_8_way. A behavioural model
//            of the round-robin rules is compared against every DUT output
//            on each falling edge; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_arbiter_16_8_way;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [15:0] din [8];
  logic        ready;
  logic [15:0] out;
  logic        valid;
  logic [7:0]  grant;
  logic [2:0]  sel;
  logic [15:0] xfer_count;

  int n_checks = 0;
  int n_fail   = 0;

  my_arbiter_16_8_way #(.PTR_INIT(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .a          (din[0]),
    .b          (din[1]),
    .c          (din[2]),
    .d          (din[3]),
    .e          (din[4]),
    .f          (din[5]),
    .g          (din[6]),
    .h          (din[7]),
    .ready      (ready),
    .out        (out),
    .valid      (valid),
    .grant      (grant),
    .sel        (sel),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr;
  bit          m_valid;
  int          m_sel;
  logic [15:0] m_out;
  int          m_count;

  // First requesting index scanning start, start+1, ... modulo 8; -1 if none.
  function automatic int first_req(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic int search_start(input bit took, input int cur_sel, input int ptr);
    return took ? (cur_sel + 1) % 8 : ptr;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ptr   <= 0;
      m_valid <= 1'b0;
      m_sel   <= 0;
      m_out   <= 16'h0000;
      m_count <= 0;
    end else begin
      if (m_valid && ready) begin
        m_count <= (m_count + 1) % 65536;
        m_ptr   <= (m_sel + 1) % 8;
      end
      // The output slot is free if empty or being emptied this edge.
      if (!m_valid || ready) begin
        if (first_req(req, search_start(m_valid && ready, m_sel, m_ptr)) >= 0) begin
          m_sel   <= first_req(req, search_start(m_valid && ready, m_sel, m_ptr));
          m_out   <= din[first_req(req, search_start(m_valid && ready, m_sel, m_ptr))];
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("out",        32'(out),        32'(m_out));
    check("valid",      32'(valid),      32'(m_valid));
    check("grant",      32'(grant),      m_valid ? 32'(8'd1 << m_sel) : 32'd0);
    check("sel",        32'(sel),        32'(m_sel));
    check("xfer_count", 32'(xfer_count), 32'(m_count));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 8'h00;
    ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_word;
    reset = 1'b1;
    req   = 8'h00;
    ready = 1'b0;
    for (int i = 0; i < 8; i++) din[i] = 16'h0000;
    step();
    step();
    reset = 1'b0;
    at_neg();
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);

    // Reset in the middle of a held transfer
    din[2] = 16'h1234;
    req    = 8'h04;
    step();
    at_neg();
    check("busy_out",   32'(out),   32'h1234);
    check("busy_valid", 32'(valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_out",   32'(out),        32'd0);
    check("async_valid", 32'(valid),      32'd0);
    check("async_grant", 32'(grant),      32'd0);
    check("async_count", 32'(xfer_count), 32'd0);
    req = 8'h00;
    step();
    reset = 1'b0;
    ready = 1'b1;   // ready with nothing valid must be ignored
    step();
    step();
    at_neg();
    check("idle_valid", 32'(valid),      32'd0);
    check("idle_count", 32'(xfer_count), 32'd0);
    ready = 1'b0;

    // Single request held under backpressure
    din[0] = 16'hBEEF;
    req    = 8'h01;
    step();
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("single_out",   32'(out),   32'hBEEF);
      check("single_sel",   32'(sel),   32'd0);
      check("single_grant", 32'(grant), 32'h01);
      step();
    end
    ready = 1'b1;
    req   = 8'h00;
    step();
    ready = 1'b0;
    at_neg();
    check("single_done_valid", 32'(valid),      32'd0);
    check("single_done_count", 32'(xfer_count), 32'd1);

    // Full contention: one grant per cycle, strict rotation
    do_reset();
    for (int i = 0; i < 8; i++) din[i] = 16'(i) * 16'h0101;
    req   = 8'hFF;
    ready = 1'b1;
    step();
    for (int i = 0; i <= 8; i++) begin
      at_neg();
      exp_word = 16'(i % 8) * 16'h0101;
      check("rr_sel",   32'(sel),        32'(i % 8));
      check("rr_out",   32'(out),        32'(exp_word));
      check("rr_count", 32'(xfer_count), 32'(i));
      step();
    end
    req = 8'h00;
    step();
    ready = 1'b0;

    // Wrap-around of the search from 7 back to 0
    do_reset();
    din[6] = 16'h6666;
    din[0] = 16'h0A0A;
    req    = 8'h40;
    step();
    at_neg();
    check("wrap_first_sel", 32'(sel), 32'd6);
    req   = 8'h41;
    ready = 1'b1;
    step();
    at_neg();
    check("wrap_next_sel", 32'(sel), 32'd0);
    check("wrap_next_out", 32'(out), 32'h0A0A);
    req = 8'h00;
    step();
    ready = 1'b0;

    // Backpressure with owner withdrawing its request
    do_reset();
    din[5] = 16'hCAFE;
    req    = 8'h20;
    step();
    req = 8'h00;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check("bp_out",   32'(out),   32'hCAFE);
      check("bp_valid", 32'(valid), 32'd1);
      step();
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    at_neg();
    check("bp_valid_after", 32'(valid),      32'd0);
    check("bp_grant_after", 32'(grant),      32'd0);
    check("bp_count_after", 32'(xfer_count), 32'd1);

    // Transfer counter wrap
    do_reset();
    req   = 8'hFF;
    ready = 1'b1;
    step();
    repeat (65535) step();
    at_neg();
    check("count_max",  32'(xfer_count), 32'hFFFF);
    step();
    at_neg();
    check("count_wrap", 32'(xfer_count), 32'h0000);
    req   = 8'h00;
    ready = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_my_arbiter_16_8_way
`default_nettype wire
